// File: rtl/aes_key_if.sv
// aes_key_if: key load handshake and round-key read port of the AES key scheduler
interface aes_key_if #(parameter int NK = 4) ();
   logic              key_valid;
   logic [0:NK*32-1]  key;
   logic              key_ready;
   logic              busy;
   logic              keys_ready;
   logic              rk_req;
   logic [3:0]        rk_idx;
   logic              rk_valid;
   logic              rk_err;
   logic [0:127]      rk;
   modport master (
      output key_valid, key, rk_req, rk_idx,
      input  key_ready, busy, keys_ready, rk_valid, rk_err, rk
   );
   modport slave (
      input  key_valid, key, rk_req, rk_idx,
      output key_ready, busy, keys_ready, rk_valid, rk_err, rk
   );
endinterface

// File: rtl/aes_key_scheduler.sv
// aes_key_scheduler: sequential AES key expansion, one word per clock, round keys served by index
module aes_key_scheduler #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic     clk,
   input  logic     rst,
   aes_key_if.slave kif
);
   localparam int NW = 4 * (NR + 1);
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{x, 3'b000} +: 8];
   endfunction
   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction
   state_t        state_q, state_d;
   logic [5:0]    i_q, i_d;
   logic [2:0]    j_q, j_d;
   logic [7:0]    rc_q, rc_d;
   logic [31:0]   w_q [NW];
   logic [0:127]  rk_q, rk_d;
   logic          rk_valid_q, rk_valid_d;
   logic          rk_err_q, rk_err_d;
   logic          accept;
   logic [31:0]   t_prev, sub_in, sub_out, t, w_new;
   logic [7:0]    rc_next;
   logic [5:0]    base;
   // shared SubWord datapath: one 4-byte S-box serves both the RotWord and the nk==8 j==4 cases
   always_comb begin
      accept  = kif.key_valid && (state_q != EXPAND);
      t_prev  = w_q[i_q - 6'd1];
      sub_in  = (j_q == 3'd0) ? {t_prev[23:0], t_prev[31:24]} : t_prev;
      sub_out = sub_word(sub_in);
      t       = (j_q == 3'd0) ? (sub_out ^ {rc_q, 24'h0}) :
                (NK == 8 && j_q == 3'd4) ? sub_out : t_prev;
      w_new   = w_q[i_q - 6'(NK)] ^ t;
      rc_next = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);
      base    = {kif.rk_idx, 2'b00};
   end
   // next-state: key accept has priority over round-key requests; j tracks i mod nk without a divider
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      rc_d       = rc_q;
      rk_d       = rk_q;
      rk_valid_d = 1'b0;
      rk_err_d   = 1'b0;
      if (accept) begin
         state_d = EXPAND;
         i_d     = 6'(NK);
         j_d     = 3'd0;
         rc_d    = 8'h01;
      end else if (state_q == EXPAND) begin
         i_d     = i_q + 6'd1;
         j_d     = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
         rc_d    = (j_q == 3'd0) ? rc_next : rc_q;
         state_d = (i_q == 6'(NW - 1)) ? READY : EXPAND;
      end else if (state_q == READY && kif.rk_req) begin
         rk_valid_d = (kif.rk_idx <= 4'(NR));
         rk_err_d   = (kif.rk_idx > 4'(NR));
         rk_d       = (kif.rk_idx <= 4'(NR)) ?
                      {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]} : rk_q;
      end
   end
   // control and read-port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         i_q        <= '0;
         j_q        <= '0;
         rc_q       <= 8'h01;
         rk_q       <= '0;
         rk_valid_q <= 1'b0;
         rk_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         rc_q       <= rc_d;
         rk_q       <= rk_d;
         rk_valid_q <= rk_valid_d;
         rk_err_q   <= rk_err_d;
      end
   end
   // word store: key words on accept, one generated word per expansion cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NK; k++) w_q[k] <= kif.key[k*32 +: 32];
      end else if (state_q == EXPAND) begin
         w_q[i_q] <= w_new;
      end
   end
   assign kif.key_ready  = (state_q == IDLE) || (state_q == READY);
   assign kif.busy       = (state_q == EXPAND);
   assign kif.keys_ready = (state_q == READY);
   assign kif.rk_valid   = rk_valid_q;
   assign kif.rk_err     = rk_err_q;
   assign kif.rk         = rk_q;
endmodule

// File: tb/tb_aes_key_scheduler.sv
// tb_aes_key_scheduler: directed FIPS-197 vectors for AES-128/192/256 key schedules
module tb_aes_key_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [2:0]   kv = '0, rq = '0;
   logic [3:0]   idx = '0;
   logic [255:0] kk = '0;
   logic [2:0]   kr, bz, kys, rv, re;
   logic [127:0] rko [3];
   int n_cmp = 0, n_bad = 0;
   aes_key_if #(.NK(4)) i4 ();
   aes_key_if #(.NK(6)) i6 ();
   aes_key_if #(.NK(8)) i8 ();
   assign i4.key_valid = kv[0];
   assign i6.key_valid = kv[1];
   assign i8.key_valid = kv[2];
   assign i4.key = kk[255 -: 128];
   assign i6.key = kk[255 -: 192];
   assign i8.key = kk;
   assign i4.rk_req = rq[0];
   assign i6.rk_req = rq[1];
   assign i8.rk_req = rq[2];
   assign i4.rk_idx = idx;
   assign i6.rk_idx = idx;
   assign i8.rk_idx = idx;
   assign kr  = {i8.key_ready, i6.key_ready, i4.key_ready};
   assign bz  = {i8.busy, i6.busy, i4.busy};
   assign kys = {i8.keys_ready, i6.keys_ready, i4.keys_ready};
   assign rv  = {i8.rk_valid, i6.rk_valid, i4.rk_valid};
   assign re  = {i8.rk_err, i6.rk_err, i4.rk_err};
   assign rko[0] = i4.rk;
   assign rko[1] = i6.rk;
   assign rko[2] = i8.rk;
   aes_key_scheduler #(.NK(4), .NR(10)) u4 (.clk(clk), .rst(rst), .kif(i4.slave));
   aes_key_scheduler #(.NK(6), .NR(12)) u6 (.clk(clk), .rst(rst), .kif(i6.slave));
   aes_key_scheduler #(.NK(8), .NR(14)) u8 (.clk(clk), .rst(rst), .kif(i8.slave));
   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KC1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // accept a key (with a simultaneous rk_req that must be dropped), then time the expansion
   task automatic load(input int s, input logic [255:0] k, input int exp_busy);
      int n;
      logic spur;
      n = 0;
      spur = 1'b0;
      kk = k;
      kv[s] = 1'b1;
      rq[s] = 1'b1;
      idx = 4'd0;
      @(posedge clk);
      #1;
      kv[s] = 1'b0;
      chk("accept_no_rk_valid", 128'(rv[s]), 128'd0);
      chk("accept_keys_ready_low", 128'(kys[s]), 128'd0);
      while (bz[s] && n < 200) begin
         n++;
         spur = spur | rv[s] | re[s];
         @(posedge clk);
         #1;
      end
      spur = spur | rv[s] | re[s];
      rq[s] = 1'b0;
      chk("busy_cycles", 128'(n), 128'(exp_busy));
      chk("expand_req_ignored", 128'(spur), 128'd0);
      chk("keys_ready", 128'(kys[s]), 128'd1);
   endtask
   task automatic rd(input int s, input logic [3:0] k, output logic [127:0] r);
      rq[s] = 1'b1;
      idx = k;
      @(posedge clk);
      #1;
      rq[s] = 1'b0;
      r = rko[s];
      chk("rk_valid", 128'(rv[s]), 128'd1);
   endtask
   initial begin
      logic [127:0] r;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk("rst_key_ready", 128'(kr[s]), 128'd1);
         chk("rst_busy", 128'(bz[s]), 128'd0);
         chk("rst_keys_ready", 128'(kys[s]), 128'd0);
         chk("rst_rk_valid", 128'(rv[s]), 128'd0);
         chk("rst_rk_err", 128'(re[s]), 128'd0);
         chk("rst_rk", rko[s], 128'd0);
      end
      kk = K128;
      kv[0] = 1'b1;
      @(posedge clk);
      #1;
      kv[0] = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("mid_expand_busy", 128'(bz[0]), 128'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_key_ready", 128'(kr[0]), 128'd1);
      chk("mid_rst_busy", 128'(bz[0]), 128'd0);
      load(0, K128, 40);
      rd(0, 4'd0, r);
      chk("aes128_rk0", r, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      rd(0, 4'd1, r);
      chk("aes128_w4", 128'(r[127:96]), 128'h0a0fafe17);
      chk("aes128_rk1", r, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(0, 4'd10, r);
      chk("aes128_rk10", r, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rq[0] = 1'b1;
      idx = 4'd11;
      @(posedge clk);
      #1;
      rq[0] = 1'b0;
      chk("idx11_rk_err", 128'(re[0]), 128'd1);
      chk("idx11_rk_valid", 128'(rv[0]), 128'd0);
      chk("idx11_rk_held", rko[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      @(posedge clk);
      #1;
      chk("rk_err_pulse", 128'(re[0]), 128'd0);
      load(0, KC1, 40);
      rd(0, 4'd0, r);
      chk("rekey_rk0", r, 128'h000102030405060708090a0b0c0d0e0f);
      rd(0, 4'd10, r);
      chk("rekey_rk10", r, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      load(1, K192, 46);
      rd(1, 4'd0, r);
      chk("aes192_rk0", r, 128'h8e73b0f7da0e6452c810f32b809079e5);
      rd(1, 4'd1, r);
      chk("aes192_w6", 128'(r[63:32]), 128'hfe0c91f7);
      rd(1, 4'd12, r);
      chk("aes192_rk12", r, 128'he98ba06f448c773c8ecc720401002202);
      load(2, K256, 52);
      rd(2, 4'd0, r);
      chk("aes256_rk0", r, 128'h603deb1015ca71be2b73aef0857d7781);
      rd(2, 4'd2, r);
      chk("aes256_w8", 128'(r[127:96]), 128'h9ba35411);
      rd(2, 4'd14, r);
      chk("aes256_rk14", r, 128'hfe4890d1e6188d0b046df344706c631e);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Sequential AES key-expansion controller. Accepts a cipher key over a valid/ready handshake and expands it into 4·(nr+1) 32-bit words, one word per clock, using a single shared SubWord/RotWord/Rcon datapath. It stores the schedule internally and serves 128-bit round keys by index to the cipher round engine. It replaces the fully unrolled combinational expansion wherever area matters more than latency.

## Interface
- nk, default 4: key length in 32-bit words. Legal values are 4, 6 and 8.
- nr, default 10: number of rounds. Legal pairs are 4/10, 6/12 and 8/14.
- clk, input, 1: sole clock; everything is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- key_valid, input, 1: key offer.
- key, input, nk·32: cipher key, big-endian ([0:nk·32-1]). w[0] = key[0:31].
- key_ready, output, 1: key can be accepted (state IDLE or READY).
- busy, output, 1: expansion in progress (state EXPAND).
- keys_ready, output, 1: full schedule valid (state READY).
- rk_req, input, 1: round-key request.
- rk_idx, input, 4: requested round, 0..nr.
- rk_valid, output, 1: rk holds the requested key (single-cycle pulse).
- rk_err, output, 1: single-cycle pulse when rk_idx > nr.
- rk, output, 128: round key {w[4i], w[4i+1], w[4i+2], w[4i+3]}, big-endian.

## Operation
- States:
  - IDLE: waits for a key.
  - EXPAND: generates one schedule word per cycle.
  - READY: schedule complete; serves round keys.
- Word store: 4·(nr+1) × 32-bit register array.
- Counters:
  - i: word index, 6 bits.
  - j: i mod nk, maintained incrementally; no divider.
  - rc: current Rcon byte, 8 bits.
- Key accept happens when key_valid && key_ready:
  - w[0..nk-1] ← key.
  - i ← nk, j ← 0, rc ← 8'h01.
  - State goes to EXPAND.
  - Accepted in either IDLE or READY. A rekey in READY discards the old schedule.
- Each EXPAND cycle:
  - t = w[i-1].
  - If j==0: t = SubWord(RotWord(t)) ^ {rc,24'h0}, then rc ← xtime(rc), where xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0).
  - Else if nk==8 and j==4: t = SubWord(t).
  - w[i] ← w[i-nk] ^ t.
  - i++, and j wraps to 0 at nk.
- When i == 4·(nr+1)-1 is written, the next state is READY.
- SubWord uses the standard FIPS-197 S-box. Exactly one 4-byte S-box instance is shared by both SubWord cases.
- Round-key read: rk_req sampled in READY with rk_idx ≤ nr gives rk_valid=1 and the key on rk in the next cycle.
  - rk_idx > nr: rk_err=1 instead; rk_valid stays 0; rk holds its previous value.
  - rk_req outside READY is ignored: no rk_valid, no rk_err.
- key_valid and rk_req in the same READY cycle: the key accept wins and the request is dropped.
- key_valid during EXPAND is not accepted (key_ready=0); the source holds it.

## Timing
- Values after reset:
  - State = IDLE.
  - key_ready = 1.
  - busy, keys_ready, rk_valid and rk_err = 0.
  - rk = 0.
  - i, j = 0; rc = 8'h01. Word store contents are don't-care.
- Reset mid-EXPAND or mid-READY returns to IDLE in the next cycle; keys_ready drops.
- A key accepted at edge 0 puts the block in EXPAND (busy=1) from cycle 1.
- EXPAND lasts 4(nr+1)-nk cycles: 40 for AES-128, 46 for AES-192, 52 for AES-256.
- keys_ready rises the cycle after the last word is written.
  - AES-128: keys_ready first high in cycle 41 after acceptance.
- keys_ready falls the cycle after a rekey is accepted.
- Round-key read latency is 1 cycle. Back-to-back requests give back-to-back rk_valid pulses.
- key_ready, busy and keys_ready are decoded from registered state, with no combinational path from inputs.

## Test plan
- AES-128 (nk=4, nr=10), key 2b7e151628aed2a6abf7158809cf4f3c:
  - busy high for exactly 40 cycles, then keys_ready.
  - rk_idx=0 returns the key.
  - rk_idx=1 gives w[4] = a0fafe17.
  - rk_idx=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 (6/12), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - 46 busy cycles.
  - w[6] = fe0c91f7.
  - rk_idx=12 returns e98ba06f448c773c8ecc720401002202.
- AES-256 (8/14), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - 52 busy cycles.
  - w[8] = 9ba35411, which checks the j==4 SubWord path.
  - rk_idx=14 returns fe4890d1e6188d0b046df344706c631e.
- Error and ignore cases:
  - rk_idx=11 with nr=10 → rk_err pulses for 1 cycle; rk_valid=0; rk unchanged.
  - rk_req during EXPAND → no response.
- Rekey in READY with a simultaneous rk_req:
  - No rk_valid.
  - keys_ready low the next cycle.
  - The new schedule is correct after 40 cycles.
- Reset asserted at EXPAND cycle 20:
  - IDLE next cycle, key_ready=1, busy=0.
  - A fresh key then expands correctly, confirming rc restarts at 01.
